// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//   Operand/result handshake bundle for serial_subtractor.
//
//   Request side (master -> slave):
//     in_valid  operands a, b, bin are presented
//     a, b      minuend / subtrahend, unsigned, WIDTH bits
//     bin       borrow-in subtracted at the LSB
//     out_ready consumer accepts the current result
//   Response side (slave -> master):
//     in_ready  block accepts operands
//     out_valid result is available
//     diff      result, WIDTH bits
//     bout      borrow-out of the full-width subtraction
//     zero      diff equals 0
//
//   WIDTH must match the WIDTH of the serial_subtractor it is bound to.
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Multi-cycle unsigned subtractor computing (a - b - bin) mod 2^WIDTH,
//   CHUNK bits per clock, LSB chunk first. A three-state FSM
//   (IDLE -> RUN -> DONE) sequences capture, NCHUNK computation cycles and
//   result hold until the consumer takes it.
//
//   Parameters:
//     WIDTH  operand/result width (multiple of CHUNK)
//     CHUNK  bits subtracted per RUN cycle (>= 1)
//   Ports:
//     clk    rising-edge clock
//     rst    synchronous active-high reset
//     bus    serial_subtractor_if.slave: in_valid/in_ready, a, b, bin,
//            out_valid/out_ready, diff, bout, zero
//
//   Build option:
//     SERIAL_SUB_SAT_EN  when defined, a final borrow forces diff to 0
//                        (unsigned saturation) with bout=1 and zero=1.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sub;
    logic             last_chunk;

    // One chunk of the subtraction. Computing in CHUNK+1 bits makes the
    // top bit the chunk borrow-out (the result is negative exactly when
    // a_chunk < b_chunk + borrow).
    always_comb begin
        a_chunk    = a_q[cnt_q*CHUNK +: CHUNK];
        b_chunk    = b_q[cnt_q*CHUNK +: CHUNK];
        chunk_sub  = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
        last_chunk = (cnt_q == CW'(NCHUNK - 1));
    end

    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end

            RUN: begin
                diff_d[cnt_q*CHUNK +: CHUNK] = chunk_sub[CHUNK-1:0];
                borrow_d                     = chunk_sub[CHUNK];
                if (last_chunk) begin
                    // Counter returns to 0 instead of running past the top chunk.
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef SERIAL_SUB_SAT_EN
                    if (chunk_sub[CHUNK]) begin
                        diff_d = '0;
                        bout_d = 1'b1;
                        zero_d = 1'b1;
                    end else begin
                        bout_d = 1'b0;
                        zero_d = (diff_d == '0);
                    end
`else
                    bout_d = chunk_sub[CHUNK];
                    zero_d = (diff_d == '0);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                // Result registers are untouched here, so they hold until
                // the consumer takes them. No operand capture this cycle.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on
    // acceptance before being read, so a reset would only cost routing.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed self-checking bench for serial_subtractor (WIDTH=8, CHUNK=2).
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8), .CHUNK(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Present operands for one cycle from a falling edge in IDLE; afterwards
    // scramble the inputs, which must not disturb the running operation.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bin);
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.bin      = ~bin;
    endtask

    // Cycles from the acceptance cycle until out_valid is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff: got %h expected 00", bus.diff); end
        n_checks++; if (bus.bout !== 1'b0 || bus.zero !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got bout=%b zero=%b expected 0 0", bus.bout, bus.zero); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b expected 1", bus.in_ready); end
        issue(8'h5A, 8'h3C, 1'b0);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got in_ready=%b expected 0", bus.in_ready); end
        wait_done(lat);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat); end
        n_checks++; if (bus.diff !== 8'h1E) begin n_fail++; $display("FAIL basic_diff: got %h expected 1e", bus.diff); end
        n_checks++; if (bus.bout !== 1'b0 || bus.zero !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got bout=%b zero=%b expected 0 0", bus.bout, bus.zero); end
        release_result();
    endtask

    task automatic test_underflow();
        int lat;
        logic [7:0] exp_diff;
        logic       exp_zero;
`ifdef SERIAL_SUB_SAT_EN
        exp_diff = 8'h00;
        exp_zero = 1'b1;
`else
        exp_diff = 8'hFF;
        exp_zero = 1'b0;
`endif
        issue(8'h00, 8'h01, 1'b0);
        wait_done(lat);
        n_checks++; if (bus.diff !== exp_diff) begin n_fail++; $display("FAIL underflow_diff: got %h expected %h", bus.diff, exp_diff); end
        n_checks++; if (bus.bout !== 1'b1 || bus.zero !== exp_zero) begin n_fail++; $display("FAIL underflow_flags: got bout=%b zero=%b expected 1 %b", bus.bout, bus.zero, exp_zero); end
        release_result();
    endtask

    task automatic test_borrow_chain();
        int lat;
        issue(8'h10, 8'h0F, 1'b1);
        wait_done(lat);
        n_checks++; if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL borrow_chain_diff: got %h expected 00", bus.diff); end
        n_checks++; if (bus.bout !== 1'b0 || bus.zero !== 1'b1) begin n_fail++; $display("FAIL borrow_chain_flags: got bout=%b zero=%b expected 0 1", bus.bout, bus.zero); end
        release_result();
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;   // wrapped result
        logic       bout;
        logic       zero;
    } vec_t;

    task automatic test_vectors();
        vec_t       v [6];
        int         lat;
        logic [7:0] exp_diff;
        logic       exp_zero;
        v[0] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        v[1] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
        v[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        v[3] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b0};
        v[4] = '{8'h33, 8'h34, 1'b1, 8'hFE, 1'b1, 1'b0};
        v[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            exp_diff = v[i].diff;
            exp_zero = v[i].zero;
`ifdef SERIAL_SUB_SAT_EN
            if (v[i].bout) begin
                exp_diff = 8'h00;
                exp_zero = 1'b1;
            end
`endif
            issue(v[i].a, v[i].b, v[i].bin);
            wait_done(lat);
            n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL vec%0d_latency: got %0d expected 5", i, lat); end
            n_checks++;
            if (bus.diff !== exp_diff || bus.bout !== v[i].bout || bus.zero !== exp_zero) begin
                n_fail++;
                $display("FAIL vec%0d_result: got diff=%h bout=%b zero=%b expected diff=%h bout=%b zero=%b",
                         i, bus.diff, bus.bout, bus.zero, exp_diff, v[i].bout, exp_zero);
            end
            release_result();
        end
    endtask

    task automatic test_hold();
        int lat;
        issue(8'hC3, 8'h41, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 3; i++) begin
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            bus.bin      = 1'($urandom);
            bus.in_valid = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.diff !== 8'h82 || bus.bout !== 1'b0 || bus.zero !== 1'b0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got diff=%h bout=%b zero=%b out_valid=%b in_ready=%b expected 82 0 0 1 0",
                         i, bus.diff, bus.bout, bus.zero, bus.out_valid, bus.in_ready);
            end
        end
        // in_valid is still high on the releasing edge: it must not be taken.
        release_result();
        n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid); end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_idle: got in_ready=%b expected 1", bus.in_ready); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        issue(8'h12, 8'h34, 1'b0);
        @(negedge clk);             // now in the second RUN cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.diff !== 8'h00 || bus.bout !== 1'b0 || bus.zero !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_outputs: got out_valid=%b diff=%h bout=%b zero=%b in_ready=%b expected 0 00 0 0 1",
                     bus.out_valid, bus.diff, bus.bout, bus.zero, bus.in_ready);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_result: got %0d out_valid cycles expected 0", seen); end
        issue(8'hFF, 8'h01, 1'b0);
        wait_done(lat);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 5", lat); end
        n_checks++; if (bus.diff !== 8'hFE || bus.bout !== 1'b0) begin n_fail++; $display("FAIL midrst_after: got diff=%h bout=%b expected fe 0", bus.diff, bus.bout); end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [7:0] va    [3];
        logic [7:0] vb    [3];
        logic [7:0] exp_d [3];
        logic       exp_b [3];
        int         acc   [3];
        logic [7:0] got_d [3];
        logic       got_b [3];
        int         issued = 0;
        int         got    = 0;
        int         cyc    = 0;
        va[0] = 8'h5A; vb[0] = 8'h3C; exp_d[0] = 8'h1E; exp_b[0] = 1'b0;
        va[1] = 8'h01; vb[1] = 8'h02; exp_b[1] = 1'b1;
`ifdef SERIAL_SUB_SAT_EN
        exp_d[1] = 8'h00;
`else
        exp_d[1] = 8'hFF;
`endif
        va[2] = 8'h77; vb[2] = 8'h11; exp_d[2] = 8'h66; exp_b[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            acc[i] = -100; got_d[i] = 8'hxx; got_b[i] = 1'bx;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.bin       = 1'b0;
        while ((issued < 3 || got < 3) && cyc < 60) begin
            if (bus.out_valid && got < 3) begin
                got_d[got] = bus.diff;
                got_b[got] = bus.bout;
                got++;
            end
            if (bus.in_ready && issued < 3) begin
                bus.a       = va[issued];
                bus.b       = vb[issued];
                acc[issued] = cyc;
                issued++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_checks++; if (got !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 3", got); end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (acc[i+1] - acc[i] !== 6) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d cycles expected 6", i, acc[i+1] - acc[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_b[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL b2b_result%0d: got diff=%h bout=%b expected diff=%h bout=%b", i, got_d[i], got_b[i], exp_d[i], exp_b[i]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_underflow();
        test_borrow_chain();
        test_vectors();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 2, meaning bits subtracted per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, with CHUNK >= 1.
REQ-003 The block SHALL have derived constant NCHUNK = WIDTH/CHUNK, the number of processing cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operands are presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-008 The block SHALL have port a, input, WIDTH bits: the minuend (unsigned).
REQ-009 The block SHALL have port b, input, WIDTH bits: the subtrahend (unsigned).
REQ-010 The block SHALL have port bin, input, 1 bit: the borrow-in, subtracted at the LSB.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a result is available.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port diff, output, WIDTH bits: the result.
REQ-014 The block SHALL have port bout, output, 1 bit: the borrow-out of the full-width subtraction.
REQ-015 The block SHALL have port zero, output, 1 bit: diff equals 0.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 In IDLE with in_valid=1, the block SHALL capture a, b and bin into internal registers, clear the chunk counter, and go to RUN.
REQ-019 In RUN, each cycle the block SHALL compute chunk k: a[k] - b[k] - borrow, starting at the LSB chunk with borrow = captured bin.
REQ-020 In RUN, each cycle the block SHALL store that CHUNK-bit result into diff[k], update the borrow register with the chunk borrow-out, and increment k.
REQ-021 After NCHUNK RUN cycles the block SHALL enter DONE, so out_valid rises exactly NCHUNK+1 cycles after the accepting edge.
REQ-022 The overall result SHALL equal (a - b - bin) mod 2^WIDTH, with bout=1 if and only if a < b + bin, treated as unsigned.
REQ-023 In DONE, diff, bout and zero SHALL stay stable until out_ready=1.
REQ-024 On a cycle in DONE with out_ready=1, the block SHALL return to IDLE; a new operand SHALL NOT be accepted in that same cycle.
REQ-025 In RUN and DONE, changes on a, b, bin or in_valid SHALL have no effect.
REQ-026 With CHUNK=WIDTH, RUN SHALL last exactly one cycle.
REQ-027 When RUN computes the top chunk, the chunk counter SHALL reset to 0 rather than wrap past NCHUNK-1.

Reset
REQ-028 On rst=1 at a clock edge, the state SHALL become IDLE, and diff, bout, zero, out_valid and the counter SHALL become 0; in_ready SHALL be 1 from the following cycle.
REQ-029 Reset asserted in RUN or DONE SHALL discard the operation in progress; no out_valid SHALL be produced for it.
REQ-030 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-031 When macro SERIAL_SUB_SAT_EN is defined, on entry to DONE with final borrow 1, diff SHALL be forced to 0, bout SHALL be 1 and zero SHALL be 1 (unsigned saturation).
REQ-032 When SERIAL_SUB_SAT_EN is undefined, diff SHALL be the wrapped result per REQ-022, with no saturation logic present.

Verification (WIDTH=8, CHUNK=2)
REQ-033 Test: a=0x5A, b=0x3C, bin=0 -> diff=0x1E, bout=0, zero=0, with out_valid 5 cycles after acceptance.
REQ-034 Test: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1 without the macro; diff=0x00, bout=1, zero=1 with SERIAL_SUB_SAT_EN.
REQ-035 Test: a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0, zero=1 (borrow-in propagates across chunks).
REQ-036 Test: hold out_ready=0 for 3 cycles in DONE while changing a and b -> diff is stable, in_ready=0; then out_ready=1 -> IDLE, and in_ready=1 the next cycle.
REQ-037 Test: assert rst for 1 cycle during the second RUN cycle -> out_valid=0 and all outputs 0; a new 0xFF-0x01 then yields diff=0xFE, bout=0.
REQ-038 Test: run back-to-back transactions with in_valid held high and out_ready=1 -> each takes 6 cycles from acceptance to the next acceptance, and results are in order.
